uart_tx_mmio_ctrl: RTL and testbench

- Memory-mapped controller between the RISC-V core load/store path and the UART transmitter.
- Decodes the UART register window and buffers core writes to TXDATA in a small FIFO.
- Sequences the transmitter one byte at a time with a start/done handshake.
- Passes all other addresses through to data memory, and exposes TX status to core loads.

---
 rtl/uart_tx_mmio_ctrl_if.sv | 34 +++
 rtl/uart_tx_mmio_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_tx_mmio_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_ctrl_if.sv
// Core load/store bus and UART transmitter handshake
// seen by the UART TX MMIO controller.
interface uart_tx_mmio_ctrl_if;
  logic        mem_valid;
  logic        MemRW_in;
  logic [2:0]  funct3;
  logic [31:0] addr_ALU_OUT;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic [31:0] dataR_mmu;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [2:0]  dm_funct3;
  logic [7:0]  uart_tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        irq_tx_empty;

  modport slave (
    input  mem_valid, MemRW_in, funct3,
    input  addr_ALU_OUT, data_w, dataR_mmu,
    input  tx_done,
    output data_r, dm_we, dm_addr, dm_funct3,
    output uart_tx_data, tx_start, irq_tx_empty
  );

  modport master (
    output mem_valid, MemRW_in, funct3,
    output addr_ALU_OUT, data_w, dataR_mmu,
    output tx_done,
    input  data_r, dm_we, dm_addr, dm_funct3,
    input  uart_tx_data, tx_start, irq_tx_empty
  );
endinterface

// File: rtl/uart_tx_mmio_ctrl.sv
// UART TX register window: TXDATA byte FIFO, STATUS, CTRL,
// transmitter sequencing and data-memory pass-through.
module uart_tx_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1600,
  parameter int          FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  uart_tx_mmio_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic hit_tx, hit_st, hit_ct, uart_hit;
  logic push_req, push, pop, flush, clr_ovf;
  logic fifo_empty, fifo_full, fsm_idle;
  logic unused_ok;

  // Address decode of the three UART registers
  always_comb begin
    hit_tx   = bus.mem_valid & (bus.addr_ALU_OUT == BASE_ADDR);
    hit_st   = bus.mem_valid & (bus.addr_ALU_OUT == BASE_ADDR + 32'd4);
    hit_ct   = bus.mem_valid & (bus.addr_ALU_OUT == BASE_ADDR + 32'd8);
    uart_hit = hit_tx | hit_st | hit_ct;
  end

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fsm_idle   = (state_q == S_IDLE);

  assign bus.dm_we        = bus.mem_valid & bus.MemRW_in & ~uart_hit;
  assign bus.dm_addr      = bus.addr_ALU_OUT;
  assign bus.dm_funct3    = bus.funct3;
  assign bus.uart_tx_data = tx_data_q;
  assign bus.tx_start     = (state_q == S_START);
  assign bus.irq_tx_empty = fsm_idle & fifo_empty;

  assign unused_ok = ^bus.data_w[31:8];

  // Load data mux: STATUS, zero for other UART regs, else memory
  always_comb begin
    bus.data_r = bus.dataR_mmu;
    unique case (1'b1)
      hit_st: bus.data_r = {27'b0, ovf_q, ~fsm_idle, fifo_empty,
                            fifo_full, fsm_idle & fifo_empty};
      hit_tx,
      hit_ct: bus.data_r = 32'h0;
      default: ;
    endcase
  end

  // Transmitter sequencing: pop in IDLE, pulse START, wait for done
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT:  if (bus.tx_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers, count and sticky overflow; flush has priority
  always_comb begin
    push_req = hit_tx & bus.MemRW_in;
    flush    = hit_ct & bus.MemRW_in & bus.data_w[1];
    clr_ovf  = hit_ct & bus.MemRW_in & bus.data_w[0];
    push     = push_req & ~flush & (~fifo_full | pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = bus.data_w[7:0];
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end else if (push_req & fifo_full & ~pop & ~flush) begin
      ovf_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mem_q     <= '{default: 8'h00};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      tx_data_q <= tx_data_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio_ctrl.sv
// Randomized self-checking bench for uart_tx_mmio_ctrl
// against a byte-queue reference model.
module tb_uart_tx_mmio_ctrl;
  localparam logic [31:0] A_TX  = 32'h0000_1600;
  localparam logic [31:0] A_ST  = 32'h0000_1604;
  localparam logic [31:0] A_CT  = 32'h0000_1608;
  localparam int          DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  uart_tx_mmio_ctrl_if bus();

  uart_tx_mmio_ctrl #(
    .BASE_ADDR (A_TX),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc_no = 0;
  int last_start = -100;
  int n_starts = 0;
  bit auto_done = 1'b0;
  int done_cnt = 0;
  logic [2:0]  cur_f3;
  logic [7:0]  exp_q[$];
  logic [31:0] s_data_r;
  logic [31:0] s_dm_addr;
  logic [2:0]  s_dm_f3;
  logic        s_dm_we;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // one bus cycle: drive at posedge+1, sample at negedge
  task automatic cyc(input logic v, input logic rw,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] mr, input logic dn);
    logic d;
    d = dn;
    if (auto_done && done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) d = 1'b1;
    end
    cur_f3 = 3'($urandom_range(0, 7));
    bus.mem_valid    = v;
    bus.MemRW_in     = rw;
    bus.addr_ALU_OUT = a;
    bus.data_w       = wd;
    bus.dataR_mmu    = mr;
    bus.funct3       = cur_f3;
    bus.tx_done      = d;
    @(negedge clk);
    s_data_r  = bus.data_r;
    s_dm_we   = bus.dm_we;
    s_dm_addr = bus.dm_addr;
    s_dm_f3   = bus.dm_funct3;
    if (bus.tx_start) begin
      if (n_starts > 0)
        chk("start_gap", 32'(cyc_no - last_start >= 3), 32'd1);
      chk("start_has_byte", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        chk("tx_byte", 32'(bus.uart_tx_data), 32'(exp_q.pop_front()));
      n_starts++;
      last_start = cyc_no;
      if (auto_done) done_cnt = $urandom_range(1, 4);
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d, $urandom, 1'b0);
  endtask

  task automatic ld(input logic [31:0] a);
    cyc(1'b1, 1'b0, a, $urandom, $urandom, 1'b0);
  endtask

  task automatic done_pulse();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit acc);
    logic [31:0] w;
    w = $urandom;
    w[7:0] = b;
    if (acc) exp_q.push_back(b);
    st(A_TX, w);
  endtask

  task automatic status_is(input string tag, input logic [31:0] exp);
    ld(A_ST);
    chk(tag, s_data_r, exp);
  endtask

  task automatic drain(input int maxc);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !bus.irq_tx_empty) && k < maxc) begin
      idle(1);
      k++;
    end
    chk("drain_in_time", 32'(k < maxc), 32'd1);
    status_is("status_after_drain", 32'h5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    int s0;
    bit ovf;
    logic [31:0] mr;
    logic [31:0] a;
    logic [7:0] burst [5];

    bus.mem_valid = 1'b0;
    bus.MemRW_in = 1'b0;
    bus.funct3 = 3'd0;
    bus.addr_ALU_OUT = 32'h0;
    bus.data_w = 32'h0;
    bus.dataR_mmu = 32'h0;
    bus.tx_done = 1'b0;

    // reset
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_irq", 32'(bus.irq_tx_empty), 32'd1);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus.uart_tx_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    status_is("status_reset", 32'h5);

    // single byte: latency and busy status
    c0 = cyc_no;
    push_byte(8'h41, 1'b1);
    idle(3);
    chk("start_latency", 32'(last_start - c0), 32'd2);
    chk("starts_single", 32'(n_starts), 32'd1);
    status_is("status_busy", 32'h0C);
    done_pulse();
    status_is("status_after_done", 32'h5);

    // burst while transmitter stalls, then overflow
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) push_byte(burst[i], 1'b1);
    status_is("status_full", 32'h0A);
    push_byte(8'h66, 1'b0);
    status_is("status_overflow", 32'h1A);
    for (int i = 0; i < 4; i++) begin
      done_pulse();
      idle(2);
    end
    st(A_CT, 32'h1);
    chk("uart_store_dm_we", 32'(s_dm_we), 32'd0);
    status_is("status_ovf_clear", 32'h0C);
    done_pulse();
    status_is("status_burst_end", 32'h5);

    // memory pass-through
    a = 32'h0000_0100;
    st(a, $urandom);
    chk("pt_dm_we", 32'(s_dm_we), 32'd1);
    chk("pt_dm_addr", s_dm_addr, a);
    chk("pt_dm_funct3", 32'(s_dm_f3), 32'(cur_f3));
    mr = $urandom;
    cyc(1'b1, 1'b0, a, 32'h0, mr, 1'b0);
    chk("pt_data_r", s_data_r, mr);
    chk("pt_load_dm_we", 32'(s_dm_we), 32'd0);
    status_is("status_pt", 32'h5);

    // reset during WAIT with two bytes queued
    for (int i = 0; i < 3; i++) push_byte(8'($urandom), 1'b1);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_irq", 32'(bus.irq_tx_empty), 32'd1);
    chk("midrst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("midrst_tx_data", 32'(bus.uart_tx_data), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    s0 = n_starts;
    done_pulse();
    idle(4);
    chk("late_done_no_start", 32'(n_starts - s0), 32'd0);
    status_is("status_after_rst", 32'h5);

    // push on full FIFO in the same cycle as the IDLE pop
    for (int i = 0; i < 5; i++) push_byte(8'($urandom), 1'b1);
    idle(1);
    status_is("status_full2", 32'h0A);
    done_pulse();
    push_byte(8'($urandom), 1'b1);
    auto_done = 1'b1;
    status_is("status_full_pop", 32'h0A);
    drain(200);

    // stalled random overflow, then flush
    auto_done = 1'b0;
    n = $urandom_range(5, 8);
    for (int i = 0; i < n; i++)
      push_byte(8'($urandom), i < DEPTH + 1);
    ovf = (n > DEPTH + 1);
    status_is("status_rand_ovf", 32'h0A | (ovf ? 32'h10 : 32'h0));
    st(A_CT, 32'h2);
    exp_q.delete();
    status_is("status_flush", 32'h0C | (ovf ? 32'h10 : 32'h0));
    st(A_CT, 32'h1);
    status_is("status_flush_clr", 32'h0C);
    done_pulse();
    status_is("status_flush_end", 32'h5);

    // randomized bursts with a responsive transmitter
    auto_done = 1'b1;
    repeat (12) begin
      n = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < n; i++) begin
        push_byte(8'($urandom), 1'b1);
        if ($urandom_range(0, 1) == 1) begin
          a = $urandom | 32'h8000_0000;
          mr = $urandom;
          cyc(1'b1, 1'b0, a, 32'h0, mr, 1'b0);
          chk("rand_pt_data_r", s_data_r, mr);
        end
        idle($urandom_range(0, 2));
      end
      drain(300);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
